// File: rtl/johnson_pkg.sv
// Shared definitions for Johnson-code producers and consumers.
package johnson_pkg;

  // Default Johnson word width; the sequence visits 2*WIDTH states.
  localparam int unsigned DEF_WIDTH    = 4;
  localparam int unsigned SEQ_LEN      = 2 * DEF_WIDTH;
  localparam int unsigned DEF_IDX_W    = $clog2(SEQ_LEN);
  localparam int unsigned DEF_LOCK_CNT = 4;
  localparam int unsigned DEF_ERR_W    = 8;

  // Sequence-tracking state of the checker.
  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } state_t;

endpackage

// File: rtl/johnson_word_decode.sv
// Combinational Johnson word legality check and state-index decode.
module johnson_word_decode
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic [WIDTH-1:0] word,
  output logic             legal_c,
  output logic [IDX_W-1:0] index_c
);

  int unsigned trans;
  int unsigned ones;

  // A legal word has at most one adjacent-bit transition; the index follows
  // from the number of ones and whether the ones sit at the top or bottom.
  always_comb begin
    trans = 0;
    ones  = 0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      trans = trans + 32'(word[i] ^ word[i+1]);
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      ones = ones + 32'(word[i]);
    end
    legal_c = (trans <= 1);
    if (word[WIDTH-1] || (word == '0)) begin
      index_c = IDX_W'(ones);
    end else begin
      index_c = IDX_W'(2 * WIDTH - ones);
    end
  end

endmodule

// File: rtl/johnson_decoder_checker.sv
// Johnson sequence monitor: decodes each sample, flags illegal words and
// broken successions, tracks lock and counts errors with saturation.
module johnson_decoder_checker
  import johnson_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned IDX_W    = DEF_IDX_W,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned LEN    = 2 * WIDTH;
  localparam int unsigned LCNT_W = $clog2(LOCK_CNT + 1);

  logic             dec_legal;
  logic [IDX_W-1:0] dec_index;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              index_valid_q, index_valid_d;
  logic              illegal_q, illegal_d;
  logic              seq_err_q, seq_err_d;
  logic              locked_q, locked_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [IDX_W-1:0]  prev_idx_q, prev_idx_d;
  logic              prev_valid_q, prev_valid_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [IDX_W-1:0]  expect_idx;
  logic              err_evt;

  johnson_word_decode #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_decode (
    .word    (din),
    .legal_c (dec_legal),
    .index_c (dec_index)
  );

  // Successor of the previous sample, wrapping from the last state to 0.
  always_comb begin
    if (prev_idx_q == IDX_W'(LEN - 1)) begin
      expect_idx = '0;
    end else begin
      expect_idx = prev_idx_q + IDX_W'(1);
    end
  end

  // Next-state and next-output evaluation for one sample.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    index_valid_d = 1'b0;
    illegal_d     = 1'b0;
    seq_err_d     = 1'b0;
    err_d         = err_q;
    prev_idx_d    = prev_idx_q;
    prev_valid_d  = prev_valid_q;
    lcnt_d        = lcnt_q;
    err_evt       = 1'b0;

    if (din_valid) begin
      if (!dec_legal) begin
        illegal_d    = 1'b1;
        prev_valid_d = 1'b0;
        err_evt      = 1'b1;
      end else begin
        index_d       = dec_index;
        index_valid_d = 1'b1;
        prev_idx_d    = dec_index;
        prev_valid_d  = 1'b1;
        if (prev_valid_q) begin
          if (dec_index != expect_idx) begin
            seq_err_d = 1'b1;
            err_evt   = 1'b1;
          end else if (state_q == ACQUIRE) begin
            lcnt_d = lcnt_q + LCNT_W'(1);
            if (lcnt_q == LCNT_W'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
            end
          end
        end
      end

      if (err_evt) begin
        state_d = ACQUIRE;
        lcnt_d  = '0;
        if (err_q != '1) begin
          err_d = err_q + ERR_W'(1);
        end
      end
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ACQUIRE;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= '0;
      prev_idx_q    <= '0;
      prev_valid_q  <= 1'b0;
      lcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      illegal_q     <= illegal_d;
      seq_err_q     <= seq_err_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      prev_idx_q    <= prev_idx_d;
      prev_valid_q  <= prev_valid_d;
      lcnt_q        <= lcnt_d;
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign illegal     = illegal_q;
  assign seq_err     = seq_err_q;
  assign locked      = locked_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Randomized self-checking bench for johnson_decoder_checker.
module tb_johnson_decoder_checker;

  localparam int TW   = 4;
  localparam int TSEQ = 2 * TW;
  localparam int TLCK = 4;
  localparam int TERR = 8;
  localparam int EMAX = (1 << TERR) - 1;

  logic          clk;
  logic          rst;
  logic [TW-1:0] din;
  logic          din_valid;
  logic [2:0]    index;
  logic          index_valid;
  logic          illegal;
  logic          seq_err;
  logic          locked;
  logic [7:0]    err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit m_prev_valid;
  int m_prev_idx;
  int m_run;
  bit m_locked;
  int m_err;
  int exp_index;
  bit exp_index_valid;
  bit exp_illegal;
  bit exp_seq_err;
  bit exp_locked;
  int cur;

  johnson_decoder_checker #(
    .WIDTH    (TW),
    .IDX_W    (3),
    .LOCK_CNT (TLCK),
    .ERR_W    (TERR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .index       (index),
    .index_valid (index_valid),
    .illegal     (illegal),
    .seq_err     (seq_err),
    .locked      (locked),
    .err_count   (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Johnson word of state k: k ones filling from the top, then ones draining
  function automatic logic [TW-1:0] word_of(input int k);
    int w;
    if (k <= TW) w = ((1 << k) - 1) << (TW - k);
    else         w = (1 << (2 * TW - k)) - 1;
    return TW'(w);
  endfunction

  function automatic int idx_of(input logic [TW-1:0] w);
    for (int k = 0; k < TSEQ; k++) begin
      if (word_of(k) == w) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_valid    = 0;
    m_prev_idx      = 0;
    m_run           = 0;
    m_locked        = 0;
    m_err           = 0;
    exp_index       = 0;
    exp_index_valid = 0;
    exp_illegal     = 0;
    exp_seq_err     = 0;
    exp_locked      = 0;
  endtask

  task automatic model_update(input bit v, input logic [TW-1:0] w);
    int idx;
    exp_index_valid = 0;
    exp_illegal     = 0;
    exp_seq_err     = 0;
    if (v) begin
      idx = idx_of(w);
      if (idx < 0) begin
        exp_illegal  = 1;
        m_prev_valid = 0;
        m_run        = 0;
        m_locked     = 0;
        if (m_err < EMAX) m_err++;
      end else begin
        exp_index       = idx;
        exp_index_valid = 1;
        if (m_prev_valid) begin
          if (idx == (m_prev_idx + 1) % TSEQ) begin
            if (!m_locked) begin
              m_run++;
              if (m_run >= TLCK) m_locked = 1;
            end
          end else begin
            exp_seq_err = 1;
            m_run       = 0;
            m_locked    = 0;
            if (m_err < EMAX) m_err++;
          end
        end
        m_prev_idx   = idx;
        m_prev_valid = 1;
      end
    end
    exp_locked = m_locked;
  endtask

  task automatic step(input bit v, input logic [TW-1:0] w);
    @(negedge clk);
    din_valid = v;
    din       = w;
    @(posedge clk);
    #1;
    if (rst) model_update(v, w);
  endtask

  task automatic drive_idx(input int k);
    step(1'b1, word_of(k));
    cur = k;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("index", int'(index), exp_index);
    chk("index_valid", int'(index_valid), int'(exp_index_valid));
    chk("illegal", int'(illegal), int'(exp_illegal));
    chk("seq_err", int'(seq_err), int'(exp_seq_err));
    chk("locked", int'(locked), int'(exp_locked));
    chk("err_count", int'(err_count), m_err);
  end

  initial begin
    logic [TW-1:0] w;
    int r;
    int guard;
    model_reset();
    cur       = 0;
    din       = '0;
    din_valid = 1'b0;
    rst       = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_index", int'(index), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // counter runs from state 0; lock on the fifth sample
    for (int k = 0; k < 12; k++) begin
      drive_idx(k % TSEQ);
      if (k == 0) chk("first_idx", int'(index), 0);
      if (k == 3) chk("pre_lock", int'(locked), 0);
      if (k == 4) chk("lock_5th", int'(locked), 1);
    end
    chk("run_seq_err", int'(seq_err), 0);
    chk("run_err", int'(err_count), 0);

    // illegal word while locked, then relock after 4 successors
    step(1'b1, 4'b1010);
    chk("ill_pulse", int'(illegal), 1);
    chk("ill_locked", int'(locked), 0);
    chk("ill_err", int'(err_count), 1);
    chk("ill_index_held", int'(index), 3);
    drive_idx((cur + 1) % TSEQ);
    chk("post_ill_seq", int'(seq_err), 0);
    for (int k = 0; k < 4; k++) begin
      drive_idx((cur + 1) % TSEQ);
      if (k == 2) chk("relock_early", int'(locked), 0);
    end
    chk("relock", int'(locked), 1);

    // skip from 1100 straight to 1111
    guard = 0;
    while (cur != 2 && guard < 20) begin
      drive_idx((cur + 1) % TSEQ);
      guard++;
    end
    chk("skip_pre_lock", int'(locked), 1);
    drive_idx(4);
    chk("skip_seq_err", int'(seq_err), 1);
    chk("skip_index", int'(index), 4);
    chk("skip_err", int'(err_count), 2);
    chk("skip_locked", int'(locked), 0);

    // valid gap while locked
    for (int k = 0; k < 6; k++) drive_idx((cur + 1) % TSEQ);
    for (int k = 0; k < 3; k++) step(1'b0, TW'($urandom));
    chk("gap_locked", int'(locked), 1);
    chk("gap_iv", int'(index_valid), 0);
    drive_idx((cur + 1) % TSEQ);
    chk("gap_resume_seq", int'(seq_err), 0);
    chk("gap_resume_lock", int'(locked), 1);

    // asynchronous reset between edges while locked
    #1 rst = 1'b0;
    #1;
    chk("arst_index", int'(index), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_err", int'(err_count), 0);
    chk("arst_iv", int'(index_valid), 0);
    model_reset();
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive_idx(5);
    chk("arst_first_seq", int'(seq_err), 0);
    chk("arst_first_idx", int'(index), 5);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        step(1'b0, TW'($urandom));
      end else if (r < 14) begin
        w = TW'($urandom);
        step(1'b1, w);
        if (idx_of(w) >= 0) cur = idx_of(w);
      end else if (r < 20) begin
        drive_idx(int'($urandom_range(0, TSEQ - 1)));
      end else begin
        drive_idx((cur + 1) % TSEQ);
      end
    end

    // saturation of the error counter
    for (int n = 0; n < 300; n++) begin
      w = TW'($urandom);
      while (idx_of(w) >= 0) w = TW'($urandom);
      step(1'b1, w);
    end
    chk("sat_err", int'(err_count), 255);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
